// File: rtl/booth_arbiter.sv
// booth_arbiter: round-robin front end sharing one pipelined Booth multiplier
// between two requesters, with in-order result routing back to the owner.
module booth_arbiter #(
  parameter int LATENCY = 4,
  parameter int MAX_OUT = 2
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        mul_start,
  output logic [7:0]  mul_data1,
  output logic [7:0]  mul_data2,
  input  logic [15:0] mul_result,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [15:0] rsp_result,
  output logic        busy
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

  logic               r_ptr;
  logic [CW-1:0]      r_cnt0;
  logic [CW-1:0]      r_cnt1;
  logic               r_mulStart;
  logic [7:0]         r_mulData1;
  logic [7:0]         r_mulData2;
  logic               r_issueId;
  logic [LATENCY-1:0] r_tagValid;
  logic [LATENCY-1:0] r_tagId;
  logic               r_rspValid;
  logic               r_rspId;
  logic [15:0]        r_rspResult;

  logic w_elig0;
  logic w_elig1;
  logic w_grant0;
  logic w_grant1;
  logic w_xfer;
  logic w_dec0;
  logic w_dec1;

  // Grants are gated by reset so ready is forced low while held in reset.
  assign w_elig0  = req0_valid && (r_cnt0 < MAX_CNT);
  assign w_elig1  = req1_valid && (r_cnt1 < MAX_CNT);
  assign w_grant0 = reset && w_elig0 && (!w_elig1 || !r_ptr);
  assign w_grant1 = reset && w_elig1 && (!w_elig0 || r_ptr);
  assign w_xfer   = w_grant0 || w_grant1;
  assign w_dec0   = r_rspValid && !r_rspId;
  assign w_dec1   = r_rspValid && r_rspId;

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign mul_start  = r_mulStart;
  assign mul_data1  = r_mulData1;
  assign mul_data2  = r_mulData2;
  assign rsp_valid  = r_rspValid;
  assign rsp_id     = r_rspId;
  assign rsp_result = r_rspResult;
  assign busy       = r_mulStart || (|r_tagValid) || r_rspValid;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_ptr      <= 1'b0;
      r_mulStart <= 1'b0;
      r_mulData1 <= '0;
      r_mulData2 <= '0;
      r_issueId  <= 1'b0;
    end else begin
      r_mulStart <= w_xfer;
      if (w_xfer) begin
        r_ptr      <= w_grant0;
        r_issueId  <= w_grant1;
        r_mulData1 <= w_grant1 ? req1_a : req0_a;
        r_mulData2 <= w_grant1 ? req1_b : req0_b;
      end
    end
  end

  // The tag pipe mirrors the multiplier depth; clearing it on reset is what
  // discards products still inside the (unflushed) multiplier.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_tagValid  <= '0;
      r_tagId     <= '0;
      r_rspValid  <= 1'b0;
      r_rspId     <= 1'b0;
      r_rspResult <= '0;
    end else begin
      r_tagValid[0] <= r_mulStart;
      r_tagId[0]    <= r_issueId;
      for (int i = 1; i < LATENCY; i++) begin
        r_tagValid[i] <= r_tagValid[i-1];
        r_tagId[i]    <= r_tagId[i-1];
      end
      r_rspValid <= r_tagValid[LATENCY-1];
      if (r_tagValid[LATENCY-1]) begin
        r_rspId     <= r_tagId[LATENCY-1];
        r_rspResult <= mul_result;
      end
    end
  end

  // A slot is released one edge after its response pulse is on the outputs.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_grant0 && !w_dec0) begin
        r_cnt0 <= r_cnt0 + CW'(1);
      end else if (!w_grant0 && w_dec0 && (r_cnt0 != '0)) begin
        r_cnt0 <= r_cnt0 - CW'(1);
      end
      if (w_grant1 && !w_dec1) begin
        r_cnt1 <= r_cnt1 + CW'(1);
      end else if (!w_grant1 && w_dec1 && (r_cnt1 != '0)) begin
        r_cnt1 <= r_cnt1 - CW'(1);
      end
    end
  end

endmodule
